// File: rtl/knight_tour_checker.sv
// knight_tour_checker
//   Watches the Knight positions reported by a tour engine on a BOARD_DIM x BOARD_DIM
//   board. Flags off-board, illegal-move, revisited-square and stall errors, and
//   declares completion once every square has been visited by legal moves.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   clr                 synchronous abort back to IDLE (clears bitmap/count/flags)
//   start, start_x/y    begin a tour at the given square (IDLE only)
//   pos_vld, pos_x/y    Knight has settled at the given square
//   tracking            high while a tour is being followed
//   done                sticky, tour completed legally
//   err, err_code       sticky error, one-hot {stall, revisit, illegal, off_board}
//   move_cnt            accepted moves since start
//
// state | meaning
// IDLE  | waiting for start; pos_vld ignored
// TRACK | following the tour, checking each reported position
// DONE  | all squares visited; terminal until clr/rst
// ERROR | first error latched in err_code; terminal until clr/rst

module knight_tour_checker #(
   parameter int BOARD_DIM = 5,
   parameter int COORD_W   = 3,
   parameter int STALL_CYC = 2000000,
   localparam int CNT_W    = $clog2(BOARD_DIM*BOARD_DIM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               start,
   input  logic [COORD_W-1:0] start_x,
   input  logic [COORD_W-1:0] start_y,
   input  logic               pos_vld,
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   output logic               tracking,
   output logic               done,
   output logic               err,
   output logic [3:0]         err_code,
   output logic [CNT_W-1:0]   move_cnt
);

   localparam int SQ      = BOARD_DIM*BOARD_DIM;
   localparam int STALL_W = $clog2(STALL_CYC);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] ERROR = 2'd3;

   localparam logic [COORD_W:0]   DIM_C      = (COORD_W+1)'(BOARD_DIM);
   localparam logic [COORD_W:0]   ONE        = (COORD_W+1)'(1);
   localparam logic [COORD_W:0]   TWO        = (COORD_W+1)'(2);
   localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(SQ-1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC-1);

   logic [1:0]         state;
   logic [SQ-1:0]      bitmap;
   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [STALL_W-1:0] stall_cnt;

   logic                      start_off;
   logic                      pos_off;
   logic                      pos_legal;
   logic                      pos_seen;
   logic [CNT_W-1:0]          start_idx;
   logic [CNT_W-1:0]          pos_idx;
   logic signed [COORD_W:0]   dx;
   logic signed [COORD_W:0]   dy;
   logic [COORD_W:0]          adx;
   logic [COORD_W:0]          ady;

   function automatic logic off_board(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return ({1'b0, x} >= DIM_C) || ({1'b0, y} >= DIM_C);
   endfunction

   function automatic logic [CNT_W-1:0] sq_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return CNT_W'(y) * CNT_W'(BOARD_DIM) + CNT_W'(x);
   endfunction

   // Index is forced to 0 for off-board squares so the bitmap is never read out of range.
   always_comb begin
      start_off = off_board(start_x, start_y);
      pos_off   = off_board(pos_x, pos_y);
      start_idx = start_off ? '0 : sq_idx(start_x, start_y);
      pos_idx   = pos_off ? '0 : sq_idx(pos_x, pos_y);
      dx        = signed'({1'b0, pos_x}) - signed'({1'b0, cur_x});
      dy        = signed'({1'b0, pos_y}) - signed'({1'b0, cur_y});
      adx       = dx[COORD_W] ? unsigned'(-dx) : unsigned'(dx);
      ady       = dy[COORD_W] ? unsigned'(-dy) : unsigned'(dy);
      pos_legal = ((adx == ONE) && (ady == TWO)) || ((adx == TWO) && (ady == ONE));
      pos_seen  = bitmap[pos_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bitmap    <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         stall_cnt <= '0;
         tracking  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
         move_cnt  <= '0;
      end else if (clr) begin
         state     <= IDLE;
         bitmap    <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         stall_cnt <= '0;
         tracking  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
         move_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Bitmap is already clear here: IDLE is only entered through rst or clr.
               if (start) begin
                  if (start_off) begin
                     state    <= ERROR;
                     err      <= 1'b1;
                     err_code <= 4'b0001;
                  end else begin
                     state             <= TRACK;
                     tracking          <= 1'b1;
                     bitmap[start_idx] <= 1'b1;
                     cur_x             <= start_x;
                     cur_y             <= start_y;
                     move_cnt          <= '0;
                     stall_cnt         <= '0;
                  end
               end
            end
            TRACK: begin
               if (pos_vld) begin
                  if (pos_off) begin
                     state    <= ERROR;
                     tracking <= 1'b0;
                     err      <= 1'b1;
                     err_code <= 4'b0001;
                  end else if (!pos_legal) begin
                     state    <= ERROR;
                     tracking <= 1'b0;
                     err      <= 1'b1;
                     err_code <= 4'b0010;
                  end else if (pos_seen) begin
                     state    <= ERROR;
                     tracking <= 1'b0;
                     err      <= 1'b1;
                     err_code <= 4'b0100;
                  end else begin
                     bitmap[pos_idx] <= 1'b1;
                     cur_x           <= pos_x;
                     cur_y           <= pos_y;
                     move_cnt        <= move_cnt + 1'b1;
                     stall_cnt       <= '0;
                     if (move_cnt + 1'b1 == LAST_CNT) begin
                        state    <= DONE;
                        tracking <= 1'b0;
                        done     <= 1'b1;
                     end
                  end
               end else if (stall_cnt == STALL_LAST) begin
                  // Leaving TRACK here means the counter never advances past STALL_LAST.
                  state    <= ERROR;
                  tracking <= 1'b0;
                  err      <= 1'b1;
                  err_code <= 4'b1000;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            default: begin
               // DONE and ERROR hold until clr or rst.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_knight_tour_checker.sv
// tb_knight_tour_checker
//   Directed bench for knight_tour_checker on a 5x5 board with a 1000-clock stall limit.
//   The driver pushes the expected output snapshot for each issued cycle into a queue;
//   the monitor pops and compares one clock after each issued cycle.

module tb_knight_tour_checker;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       start;
   logic [2:0] start_x;
   logic [2:0] start_y;
   logic       pos_vld;
   logic [2:0] pos_x;
   logic [2:0] pos_y;
   logic       tracking;
   logic       done;
   logic       err;
   logic [3:0] err_code;
   logic [4:0] move_cnt;

   knight_tour_checker #(
      .BOARD_DIM (5),
      .COORD_W   (3),
      .STALL_CYC (1000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .start    (start),
      .start_x  (start_x),
      .start_y  (start_y),
      .pos_vld  (pos_vld),
      .pos_x    (pos_x),
      .pos_y    (pos_y),
      .tracking (tracking),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .move_cnt (move_cnt)
   );

   typedef struct {
      string      name;
      logic       trk;
      logic       dn;
      logic       er;
      logic [3:0] code;
      logic [4:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   logic obs;
   int   n_cmp;
   int   n_err;

   // Legal open tour on 5x5 starting from (2,0).
   int tour_x[24] = '{4,3,1,0,1,2,0,1,3,4,3,1,0,2,4,3,1,0,2,4,3,4,2,0};
   int tour_y[24] = '{1,3,4,2,0,2,1,3,4,2,0,1,3,4,3,1,2,4,3,4,2,0,1,0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input string n, input logic t, input logic d,
                               input logic [3:0] c, input logic [4:0] m);
      exp_t e;
      e.name = n;
      e.trk  = t;
      e.dn   = d;
      e.er   = |c;
      e.code = c;
      e.cnt  = m;
      return e;
   endfunction

   task automatic compare(input exp_t e);
      n_cmp++;
      if (tracking !== e.trk || done !== e.dn || err !== e.er ||
          err_code !== e.code || move_cnt !== e.cnt) begin
         n_err++;
         $display("FAIL %s: got tracking=%0b done=%0b err=%0b err_code=%b move_cnt=%0d, expected tracking=%0b done=%0b err=%0b err_code=%b move_cnt=%0d",
                  e.name, tracking, done, err, err_code, move_cnt,
                  e.trk, e.dn, e.er, e.code, e.cnt);
      end
   endtask

   // Monitor: an issued cycle is visible at the next posedge; outputs are sampled 1 time unit later.
   initial begin
      logic take;
      exp_t e;
      forever begin
         @(posedge clk);
         take = obs;
         #1;
         if (take) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
               e = sb_q.pop_front();
               compare(e);
            end
         end
      end
   end

   // Called at a negedge: drives one cycle of stimulus, returns at the following negedge.
   task automatic drive(input exp_t e, input logic s, input logic [2:0] sx, input logic [2:0] sy,
                        input logic v, input logic [2:0] px, input logic [2:0] py, input logic c);
      start   = s;
      start_x = sx;
      start_y = sy;
      pos_vld = v;
      pos_x   = px;
      pos_y   = py;
      clr     = c;
      sb_q.push_back(e);
      obs     = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      pos_vld = 1'b0;
      clr     = 1'b0;
      obs     = 1'b0;
   endtask

   task automatic do_start(input string n, input int x, input int y, input exp_t e);
      drive(e, 1'b1, 3'(x), 3'(y), 1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   task automatic do_pos(input int x, input int y, input exp_t e);
      drive(e, 1'b0, 3'd0, 3'd0, 1'b1, 3'(x), 3'(y), 1'b0);
   endtask

   task automatic do_clr(input string n);
      drive(mk(n, 1'b0, 1'b0, 4'b0000, 5'd0), 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
   endtask

   task automatic do_idle(input exp_t e);
      drive(e, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      obs     = 1'b0;
      rst     = 1'b1;
      clr     = 1'b0;
      start   = 1'b0;
      start_x = '0;
      start_y = '0;
      pos_vld = 1'b0;
      pos_x   = '0;
      pos_y   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_idle(mk("reset_state", 1'b0, 1'b0, 4'b0000, 5'd0));
      do_pos(1, 2, mk("idle_pos_ignored", 1'b0, 1'b0, 4'b0000, 5'd0));

      // Full legal tour
      do_start("t1", 2, 0, mk("t1_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      for (int i = 0; i < 24; i++) begin
         do_pos(tour_x[i], tour_y[i],
                mk($sformatf("t1_move%0d", i+1), (i < 23), (i == 23), 4'b0000, 5'(i+1)));
      end
      do_pos(2, 1, mk("t1_done_pos_ignored", 1'b0, 1'b1, 4'b0000, 5'd24));
      do_start("t1", 0, 0, mk("t1_done_start_ignored", 1'b0, 1'b1, 4'b0000, 5'd24));
      do_clr("t1_clr");

      // Illegal move; start while tracking is ignored
      do_start("t2", 2, 0, mk("t2_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      do_pos(4, 1, mk("t2_move1", 1'b1, 1'b0, 4'b0000, 5'd1));
      do_start("t2", 0, 0, mk("t2_restart_ignored", 1'b1, 1'b0, 4'b0000, 5'd1));
      do_pos(4, 3, mk("t2_illegal", 1'b0, 1'b0, 4'b0010, 5'd1));
      do_clr("t2_clr");

      // Revisit of the starting square
      do_start("t3", 2, 0, mk("t3_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      do_pos(0, 1, mk("t3_move1", 1'b1, 1'b0, 4'b0000, 5'd1));
      do_pos(2, 0, mk("t3_revisit", 1'b0, 1'b0, 4'b0100, 5'd1));
      do_pos(2, 2, mk("t3_error_pos_ignored", 1'b0, 1'b0, 4'b0100, 5'd1));
      do_clr("t3_clr");

      // Off-board position and off-board start; clr beats a simultaneous start
      do_start("t4", 2, 0, mk("t4_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      do_pos(5, 1, mk("t4_off_board_pos", 1'b0, 1'b0, 4'b0001, 5'd0));
      do_clr("t4_clr");
      do_start("t4", 7, 0, mk("t4_off_board_start", 1'b0, 1'b0, 4'b0001, 5'd0));
      drive(mk("t4_clr_beats_start", 1'b0, 1'b0, 4'b0000, 5'd0),
            1'b1, 3'd2, 3'd0, 1'b1, 3'd4, 3'd1, 1'b1);
      do_start("t4", 4, 4, mk("t4_corner_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      do_clr("t4_clr2");

      // Stall: error on the 1000th tracking clock without pos_vld
      do_start("t5", 0, 0, mk("t5_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      repeat (998) @(negedge clk);
      do_idle(mk("t5_before_stall", 1'b1, 1'b0, 4'b0000, 5'd0));
      do_idle(mk("t5_stall", 1'b0, 1'b0, 4'b1000, 5'd0));
      do_pos(1, 2, mk("t5_pos_after_stall", 1'b0, 1'b0, 4'b1000, 5'd0));
      do_clr("t5_clr");

      // Asynchronous reset mid-tour, then start+pos_vld in the same clock
      do_start("t6", 2, 0, mk("t6_start", 1'b1, 1'b0, 4'b0000, 5'd0));
      for (int i = 0; i < 5; i++) begin
         do_pos(tour_x[i], tour_y[i],
                mk($sformatf("t6_move%0d", i+1), 1'b1, 1'b0, 4'b0000, 5'(i+1)));
      end
      #2;
      rst = 1'b1;
      #1;
      compare(mk("t6_async_rst", 1'b0, 1'b0, 4'b0000, 5'd0));
      @(negedge clk);
      rst = 1'b0;
      drive(mk("t6_start_beats_pos", 1'b1, 1'b0, 4'b0000, 5'd0),
            1'b1, 3'd2, 3'd0, 1'b1, 3'd4, 3'd1, 1'b0);
      do_pos(4, 1, mk("t6_first_move", 1'b1, 1'b0, 4'b0000, 5'd1));

      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
